// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard front end: pin sync, frame check, set-2 decode, ASCII byte output
//
// Parameters:
//   TIMEOUT_CYCLES   idle clk_in cycles before a partial frame is abandoned
//   FIFO_DEPTH_LOG2  log2 of the output FIFO depth (FIFO build only)
// Build option:
//   PS2KBD_FIFO_EN   defined: output queue is a 2**FIFO_DEPTH_LOG2-entry FIFO
//                    undefined: single holding register
// Ports:
//   clk_in       system clock
//   rst_in       synchronous active-high reset
//   ps2_clk_in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  raw PS/2 data pin (asynchronous)
//   data_out     ASCII character, bit 7 always 0
//   valid_out    data_out holds a character
//   ready_in     consumer accepts when valid_out & ready_in at a rising edge
//   error_out    one-cycle pulse on framing, parity, timeout or overflow error
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       error_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_depth
    $error("FIFO_DEPTH_LOG2 must be at least 1");
  end

  // Pin synchronizers; idle-high reset values avoid a false edge after reset.
  logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame FSM
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;
  frame_state_t state, state_nxt;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          frame_err;
  logic          byte_done;
  logic          rx_stb;
  logic [7:0]    rx_byte;

  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_err = 1'b0;
    byte_done = 1'b0;
    if (timeout) begin
      state_nxt = ST_IDLE;
      frame_err = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s2) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (dat_s2 && par_ok) byte_done = 1'b1;
          else                  frame_err = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
      rx_stb  <= 1'b0;
      rx_byte <= 8'd0;
    end else begin
      rx_stb <= byte_done;
      if (byte_done) rx_byte <= shreg;
      if (state == ST_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= 3'd0;
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_ok <= ^{shreg, dat_s2};  // odd parity over data + parity
          default:   ;
        endcase
      end
    end
  end

  // Set-2 translation: {unshifted, shifted}; 0 in the unshifted half means unmapped.
  function automatic logic [15:0] xlate(input logic [7:0] code);
    xlate = 16'h0000;
    case (code)
      8'h1C: xlate = {8'h61, 8'h41};  8'h32: xlate = {8'h62, 8'h42};
      8'h21: xlate = {8'h63, 8'h43};  8'h23: xlate = {8'h64, 8'h44};
      8'h24: xlate = {8'h65, 8'h45};  8'h2B: xlate = {8'h66, 8'h46};
      8'h34: xlate = {8'h67, 8'h47};  8'h33: xlate = {8'h68, 8'h48};
      8'h43: xlate = {8'h69, 8'h49};  8'h3B: xlate = {8'h6A, 8'h4A};
      8'h42: xlate = {8'h6B, 8'h4B};  8'h4B: xlate = {8'h6C, 8'h4C};
      8'h3A: xlate = {8'h6D, 8'h4D};  8'h31: xlate = {8'h6E, 8'h4E};
      8'h44: xlate = {8'h6F, 8'h4F};  8'h4D: xlate = {8'h70, 8'h50};
      8'h15: xlate = {8'h71, 8'h51};  8'h2D: xlate = {8'h72, 8'h52};
      8'h1B: xlate = {8'h73, 8'h53};  8'h2C: xlate = {8'h74, 8'h54};
      8'h3C: xlate = {8'h75, 8'h55};  8'h2A: xlate = {8'h76, 8'h56};
      8'h1D: xlate = {8'h77, 8'h57};  8'h22: xlate = {8'h78, 8'h58};
      8'h35: xlate = {8'h79, 8'h59};  8'h1A: xlate = {8'h7A, 8'h5A};
      8'h16: xlate = {8'h31, 8'h21};  8'h1E: xlate = {8'h32, 8'h40};
      8'h26: xlate = {8'h33, 8'h23};  8'h25: xlate = {8'h34, 8'h24};
      8'h2E: xlate = {8'h35, 8'h25};  8'h36: xlate = {8'h36, 8'h5E};
      8'h3D: xlate = {8'h37, 8'h26};  8'h3E: xlate = {8'h38, 8'h2A};
      8'h46: xlate = {8'h39, 8'h28};  8'h45: xlate = {8'h30, 8'h29};
      8'h0E: xlate = {8'h60, 8'h7E};  8'h4E: xlate = {8'h2D, 8'h5F};
      8'h55: xlate = {8'h3D, 8'h2B};  8'h54: xlate = {8'h5B, 8'h7B};
      8'h5B: xlate = {8'h5D, 8'h7D};  8'h5D: xlate = {8'h5C, 8'h7C};
      8'h4C: xlate = {8'h3B, 8'h3A};  8'h52: xlate = {8'h27, 8'h22};
      8'h41: xlate = {8'h2C, 8'h3C};  8'h49: xlate = {8'h2E, 8'h3E};
      8'h4A: xlate = {8'h2F, 8'h3F};  8'h29: xlate = {8'h20, 8'h20};
      8'h5A: xlate = {8'h0D, 8'h0D};  8'h66: xlate = {8'h08, 8'h08};
      8'h76: xlate = {8'h1B, 8'h1B};  8'h0D: xlate = {8'h09, 8'h09};
      default: xlate = 16'h0000;
    endcase
  endfunction

  // Decoder
  logic       brk_pend, ext_pend, shift_q, ctrl_q, caps_q;
  logic [7:0] xl_lo, xl_hi;
  logic       is_letter, is_mod;
  logic       char_stb;
  logic [7:0] char_val;

  assign {xl_lo, xl_hi} = xlate(rx_byte);
  assign is_letter = (xl_lo >= 8'h61) && (xl_lo <= 8'h7A);
  assign is_mod    = (rx_byte == 8'h12) || (rx_byte == 8'h59) ||
                     (rx_byte == 8'h14) || (rx_byte == 8'h58);

  always_comb begin
    char_stb = 1'b0;
    char_val = 8'h00;
    if (rx_stb && rx_byte != 8'hF0 && rx_byte != 8'hE0 && !brk_pend) begin
      if (ext_pend) begin
        if (rx_byte == 8'h5A) begin
          char_stb = 1'b1;
          char_val = 8'h0D;
        end
      end else if (!is_mod && xl_lo != 8'h00) begin
        char_stb = 1'b1;
        if (is_letter && ctrl_q)  char_val = xl_hi & 8'h1F;
        else if (is_letter)       char_val = (shift_q ^ caps_q) ? xl_hi : xl_lo;
        else                      char_val = shift_q ? xl_hi : xl_lo;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= 1'b1;
    end else if (rx_stb) begin
      if (rx_byte == 8'hF0) begin
        brk_pend <= 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext_pend <= 1'b1;
      end else begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
        if (brk_pend) begin
          if (rx_byte == 8'h12 || rx_byte == 8'h59) shift_q <= 1'b0;
          if (rx_byte == 8'h14)                     ctrl_q  <= 1'b0;
        end else if (ext_pend) begin
          if (rx_byte == 8'h14) ctrl_q <= 1'b1;
        end else begin
          if (rx_byte == 8'h12 || rx_byte == 8'h59) shift_q <= 1'b1;
          if (rx_byte == 8'h14)                     ctrl_q  <= 1'b1;
          if (rx_byte == 8'h58)                     caps_q  <= ~caps_q;
        end
      end
    end
  end

  // Output queue
  logic pop, ovf;
  assign pop = valid_out & ready_in;

`ifdef PS2KBD_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                     full, empty, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  // A pop in the same cycle frees the slot a full queue needs.
  assign push_ok = char_stb && (!full || pop);
  assign ovf     = char_stb && full && !pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= char_val;
  end

  assign valid_out = !empty;
  assign data_out  = empty ? 8'h00 : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
`else
  logic [7:0] hold_q;
  logic       hold_vld;

  // The holding register counts as full while occupied, even if drained this cycle.
  assign ovf = char_stb && hold_vld;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_q   <= 8'h00;
      hold_vld <= 1'b0;
    end else begin
      if (pop) hold_vld <= 1'b0;
      if (char_stb && !hold_vld) begin
        hold_q   <= char_val;
        hold_vld <= 1'b1;
      end
    end
  end

  assign valid_out = hold_vld;
  assign data_out  = hold_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) error_out <= 1'b0;
    else        error_out <= frame_err | ovf;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard
module tb_ps2_keyboard;
  localparam int TO = 300;
  localparam int HP = 10;
`ifdef PS2KBD_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       error_out;

  ps2_keyboard #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH_LOG2(2)) dut (
    .clk_in(clk), .rst_in(rst), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_dat),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready), .error_out(error_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  bit err_prev = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp[$];

  bit m_shift, m_ctrl, m_caps, m_brk, m_ext;

  logic [7:0] let_code [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] oth_code [26] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
                                8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,
                                8'h4A,8'h29,8'h5A,8'h66,8'h76,8'h0D};
  logic [7:0] oth_lo [26]   = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30,
                                8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,
                                8'h2F,8'h20,8'h0D,8'h08,8'h1B,8'h09};
  logic [7:0] oth_hi [26]   = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29,
                                8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,
                                8'h3F,8'h20,8'h0D,8'h08,8'h1B,8'h09};

  // Consumer and error monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (valid_out && ready) got.push_back(data_out);
    if (error_out) begin
      err_cnt++;
      vectors++;
      if (err_prev) begin
        miscompares++;
        $display("FAIL error_pulse_width: error_out high two cycles running, required one");
      end
    end
    err_prev = error_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_shift = 0; m_ctrl = 0; m_caps = 1; m_brk = 0; m_ext = 0;
  endfunction

  // Reference keyboard model: returns ASCII code or -1 for no output.
  function automatic int model_byte(input logic [7:0] b);
    int ch = -1;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      if (b == 8'h14) m_ctrl = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (m_ext) begin
        if (b == 8'h14) m_ctrl = 1;
        else if (b == 8'h5A) ch = 13;
      end else if (b == 8'h12 || b == 8'h59) m_shift = 1;
      else if (b == 8'h14) m_ctrl = 1;
      else if (b == 8'h58) m_caps = !m_caps;
      else begin
        for (int i = 0; i < 26; i++)
          if (let_code[i] == b)
            ch = m_ctrl ? ((65 + i) % 32) : ((m_shift != m_caps) ? 65 + i : 97 + i);
        for (int i = 0; i < 26; i++)
          if (oth_code[i] == b) ch = m_shift ? int'(oth_hi[i]) : int'(oth_lo[i]);
      end
      m_brk = 0; m_ext = 0;
    end
    return ch;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_dat = 1'b1;
    wait_cyc(HP);
  endtask

  task automatic send_code(input logic [7:0] code);
    int ch;
    send_frame(code, 1'b0, 1'b0);
    ch = model_byte(code);
    if (ch >= 0) exp.push_back(8'(ch));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %02h want 00", data_out); end
    vectors++; if (error_out !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0b want 0", error_out); end
    rst = 1'b0;
    model_reset();
    wait_cyc(3);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %0b want 0", valid_out); end
  endtask

  task automatic test_first_char();
    int ch;
    got.delete(); exp.delete();
    ready = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(bit'((8'h1C >> i) & 1));
    ps2_bit(~^8'h1C);
    ps2_dat = 1'b1;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(3);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL latency_early: valid_out %0b at N+1, want 0", valid_out); end
    wait_cyc(1);
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL latency_n2: valid_out %0b at N+2, want 1", valid_out); end
    vectors++; if (data_out !== 8'h41) begin miscompares++; $display("FAIL first_char: got %02h want 41", data_out); end
    wait_cyc(HP - 4);
    ps2_clk = 1'b1;
    wait_cyc(HP);
    ch = model_byte(8'h1C);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(7);
      vectors++;
      if (valid_out !== 1'b1 || data_out !== 8'(ch)) begin
        miscompares++; $display("FAIL hold: valid %0b data %02h want 1 %02h", valid_out, data_out, 8'(ch));
      end
    end
    ready = 1'b1;
    wait_cyc(3);
    vectors++; if (got.size() != 1 || got[0] !== 8'h41) begin miscompares++; $display("FAIL first_drain: got %0d items want one 41", got.size()); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL after_pop_valid: got %0b want 0", valid_out); end
  endtask

  task automatic test_modifiers();
    logic [7:0] seq [15] = '{8'h58,8'h1C,8'h12,8'h1C,8'hF0,8'h12,8'h1C,8'h14,8'h21,8'hF0,8'h14,8'hE0,8'h5A,8'hE0,8'h75};
    logic [7:0] want [5] = '{8'h61,8'h41,8'h61,8'h03,8'h0D};
    int e0;
    got.delete(); exp.delete();
    ready = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 15; i++) send_code(seq[i]);
    wait_cyc(5);
    vectors++;
    if (got.size() != 5) begin
      miscompares++; $display("FAIL modifiers_count: got %0d chars want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (got[i] !== want[i] || exp[i] !== want[i]) begin
          miscompares++; $display("FAIL modifiers_char%0d: got %02h want %02h", i, got[i], want[i]);
        end
      end
    end
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL modifiers_err: got %0d errors want 0", err_cnt - e0); end
  endtask

  task automatic test_errors();
    int e0;
    got.delete(); exp.delete();
    ready = 1'b1;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(5);
    vectors++; if (err_cnt - e0 != 2) begin miscompares++; $display("FAIL frame_errors: got %0d pulses want 2", err_cnt - e0); end
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL frame_err_output: got %0d chars want 0", got.size()); end
    send_code(8'h45);
    wait_cyc(5);
    vectors++; if (got.size() != 1 || got[0] !== 8'h30) begin miscompares++; $display("FAIL after_error_char: got %0d chars want one 30", got.size()); end
  endtask

  task automatic test_timeout();
    int e0, cnt;
    got.delete(); exp.delete();
    ready = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    ps2_dat = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    cnt = 0;
    while (cnt < TO + 50 && err_cnt == e0) begin
      wait_cyc(1);
      cnt++;
      if (cnt == HP) ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    vectors++;
    if (cnt < TO || cnt > TO + 8) begin
      miscompares++; $display("FAIL timeout_delay: error after %0d cycles want %0d..%0d", cnt, TO, TO + 8);
    end
    wait_cyc(5);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL timeout_pulses: got %0d want 1", err_cnt - e0); end
    send_code(8'h1C);
    wait_cyc(5);
    vectors++; if (got.size() != 1 || exp.size() != 1 || got[0] !== exp[0]) begin miscompares++; $display("FAIL after_timeout_char: got %0d chars want one", got.size()); end
  endtask

  task automatic test_reset_midframe();
    int e0;
    got.delete(); exp.delete();
    ready = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    model_reset();
    ps2_dat = 1'b1;
    wait_cyc(TO + 20);
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL midframe_reset_err: got %0d pulses want 0", err_cnt - e0); end
    send_code(8'h1C);
    wait_cyc(5);
    vectors++; if (got.size() != 1 || got[0] !== 8'h41) begin miscompares++; $display("FAIL midframe_reset_char: got %0d chars want one 41", got.size()); end
  endtask

  task automatic test_overflow();
    int e0;
    got.delete(); exp.delete();
    ready = 1'b0;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_code(let_code[$urandom_range(0, 25)]);
    wait_cyc(5);
    vectors++; if (err_cnt - e0 != 5 - CAP) begin miscompares++; $display("FAIL overflow_errors: got %0d want %0d", err_cnt - e0, 5 - CAP); end
    vectors++; if (valid_out !== 1'b1 || data_out !== exp[0]) begin miscompares++; $display("FAIL overflow_head: valid %0b data %02h want 1 %02h", valid_out, data_out, exp[0]); end
    while (exp.size() > CAP) void'(exp.pop_back());
    @(posedge clk); #1;
    ready = 1'b1;
    wait_cyc(10);
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++; $display("FAIL overflow_drain_count: got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        vectors++;
        if (got[i] !== exp[i]) begin miscompares++; $display("FAIL overflow_drain%0d: got %02h want %02h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_random();
    int e0, r;
    logic [7:0] unm [4] = '{8'h05, 8'h07, 8'h0C, 8'h83};
    logic [7:0] extc [4] = '{8'h5A, 8'h75, 8'h14, 8'h12};
    got.delete(); exp.delete();
    ready = 1'b1;
    e0 = err_cnt;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: send_code(let_code[$urandom_range(0, 25)]);
        3, 4:    send_code(oth_code[$urandom_range(0, 25)]);
        5:       send_code(unm[$urandom_range(0, 3)]);
        6:       send_code($urandom_range(0, 1) ? 8'h12 : 8'h59);
        7:       begin send_code(8'hF0); send_code($urandom_range(0, 1) ? 8'h12 : 8'h59); end
        8:       begin send_code(8'h58); send_code(8'hF0); send_code(8'h58); end
        9:       begin if ($urandom_range(0, 1)) send_code(8'hF0); send_code(8'h14); end
        10:      begin send_code(8'hE0); if ($urandom_range(0, 2) == 0) send_code(8'hF0); send_code(extc[$urandom_range(0, 3)]); end
        default: begin send_code(8'hF0); send_code(let_code[$urandom_range(0, 25)]); end
      endcase
    end
    wait_cyc(5);
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL random_err: got %0d pulses want 0", err_cnt - e0); end
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++; $display("FAIL random_count: got %0d chars want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        vectors++;
        if (got[i] !== exp[i]) begin miscompares++; $display("FAIL random_char%0d: got %02h want %02h", i, got[i], exp[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_char();
    test_modifiers();
    test_errors();
    test_timeout();
    test_reset_midframe();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
